// File: rtl/booth_mul_arbiter_if.sv
// Handshake bundle between two operand requesters, the shared Booth
// multiplier and the product consumer.
interface booth_mul_arbiter_if #(
  parameter int WIDTH = 8
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [WIDTH-1:0]     req0_a;
  logic [WIDTH-1:0]     req0_b;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [WIDTH-1:0]     req1_a;
  logic [WIDTH-1:0]     req1_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [2*WIDTH-1:0]   res_product;
  logic                 res_id;
  logic                 busy;

  // Requester/consumer side: drives operands and accepts products.
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_product, res_id, busy
  );

  // Multiplier side: grants requests and presents products.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_product, res_id, busy
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Two-requester round-robin front end feeding a sequential radix-2 Booth
// multiplier. One operand pair is accepted in IDLE, WIDTH Booth steps are
// run one per cycle, and the signed product is held in DONE until taken.
module booth_mul_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  booth_mul_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic                 ptr_q;
  logic                 armed_q;
  logic                 id_q;
  logic [CNT_W-1:0]     count_q;
  logic [WIDTH:0]       accA_q;
  logic [WIDTH-1:0]     mulQ_q;
  logic [WIDTH-1:0]     mcandM_q;
  logic                 qm1_q;
  logic                 resValid_q;
  logic                 resId_q;
  logic                 busy_q;
  logic [2*WIDTH-1:0]   resProduct_q;

  logic                 grant;
  logic                 canAccept;
  logic                 ready0;
  logic                 ready1;
  logic                 accept;
  logic [WIDTH-1:0]     selA;
  logic [WIDTH-1:0]     selB;

  logic [WIDTH:0]       mExt;
  logic [WIDTH:0]       boothSum;
  logic [WIDTH:0]       accA_d;
  logic [WIDTH-1:0]     mulQ_d;
  logic                 qm1_d;
  logic [2*WIDTH-1:0]   finalProduct;

  // Round-robin pick: the pointer breaks ties, a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ptr_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  // armed_q keeps the first edge after reset release from accepting.
  assign canAccept = (state_q == IDLE) && armed_q;
  assign ready0    = canAccept && !grant && bus.req0_valid;
  assign ready1    = canAccept &&  grant && bus.req1_valid;
  assign accept    = ready0 || ready1;
  assign selA      = grant ? bus.req1_a : bus.req0_a;
  assign selB      = grant ? bus.req1_b : bus.req0_b;

  // The multiplicand is sign-extended so that A never overflows.
  assign mExt = {mcandM_q[WIDTH-1], mcandM_q};

  // One Booth step: add/subtract M by {Q0,q-1}, then arithmetic shift right.
  always_comb begin
    boothSum = accA_q;
    case ({mulQ_q[0], qm1_q})
      2'b10:   boothSum = accA_q - mExt;
      2'b01:   boothSum = accA_q + mExt;
      default: boothSum = accA_q;
    endcase
    accA_d       = {boothSum[WIDTH], boothSum[WIDTH:1]};
    mulQ_d       = {boothSum[0], mulQ_q[WIDTH-1:1]};
    qm1_d        = mulQ_q[0];
    finalProduct = {accA_d[WIDTH-1:0], mulQ_d};
  end

  // Control FSM together with the datapath and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      armed_q      <= 1'b0;
      id_q         <= 1'b0;
      count_q      <= '0;
      accA_q       <= '0;
      mulQ_q       <= '0;
      mcandM_q     <= '0;
      qm1_q        <= 1'b0;
      resValid_q   <= 1'b0;
      resId_q      <= 1'b0;
      busy_q       <= 1'b0;
      resProduct_q <= '0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            count_q  <= '0;
            accA_q   <= '0;
            qm1_q    <= 1'b0;
            mulQ_q   <= selB;
            mcandM_q <= selA;
            id_q     <= grant;
            ptr_q    <= ~grant;
          end
        end
        RUN: begin
          accA_q  <= accA_d;
          mulQ_q  <= mulQ_d;
          qm1_q   <= qm1_d;
          count_q <= count_q + 1'b1;
          if (count_q == CNT_W'(WIDTH - 1)) begin
            state_q      <= DONE;
            resValid_q   <= 1'b1;
            resProduct_q <= finalProduct;
            resId_q      <= id_q;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state_q    <= IDLE;
            resValid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          resValid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.res_valid   = resValid_q;
  assign bus.res_product = resProduct_q;
  assign bus.res_id      = resId_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed and randomised bench for the arbitrated Booth multiplier (WIDTH=8).
module tb_booth_mul_arbiter;

  localparam int WIDTH = 8;
  localparam int NVEC  = 10;

  typedef struct {
    logic        id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   vecCount;
  int   misCount;
  vec_t vecs [NVEC];

  booth_mul_arbiter_if #(.WIDTH(WIDTH)) bus ();

  booth_mul_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something unforeseen stalls the run.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      misCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyReset();
    rst_n          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full transaction on requester id: accept, latency, product, handshake.
  task automatic applyStimulus(input logic id, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] exp, input string tag);
    int   waited;
    int   lat;
    logic gotReady;
    @(negedge clk);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end
    bus.res_ready = 1'b1;
    #1;
    waited   = 0;
    gotReady = id ? bus.req1_ready : bus.req0_ready;
    while (!gotReady && waited < 20) begin
      @(negedge clk); #1;
      waited++;
      gotReady = id ? bus.req1_ready : bus.req0_ready;
    end
    checkOutput({tag, "_ready"}, {31'd0, gotReady}, 32'd1);
    if (gotReady) begin
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
      bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
      lat = 0;
      while (!bus.res_valid && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'd8);
      checkOutput({tag, "_product"}, {16'd0, bus.res_product}, {16'd0, exp});
      checkOutput({tag, "_id"}, {31'd0, bus.res_id}, {31'd0, id});
      @(posedge clk); #1;
      checkOutput({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    end else begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
  endtask

  initial begin
    int          grants [4];
    int          nGrant;
    int          nRes;
    int          waited;
    logic [15:0] heldP;
    logic        rid;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] rexp;

    vecCount = 0;
    misCount = 0;

    vecs[0] = '{1'b0, 8'd3,    8'hFB, 16'hFFF1};
    vecs[1] = '{1'b1, 8'h80,   8'h80, 16'h4000};
    vecs[2] = '{1'b1, 8'd127,  8'h80, 16'hC080};
    vecs[3] = '{1'b0, 8'hF9,   8'd9,  16'hFFC1};
    vecs[4] = '{1'b0, 8'd0,    8'd55, 16'h0000};
    vecs[5] = '{1'b1, 8'd127,  8'd127, 16'h3F01};
    vecs[6] = '{1'b0, 8'hFF,   8'hFF, 16'h0001};
    vecs[7] = '{1'b1, 8'h80,   8'd127, 16'hC080};
    vecs[8] = '{1'b0, 8'd1,    8'h80, 16'hFF80};
    vecs[9] = '{1'b1, 8'd64,   8'd2,  16'h0080};

    bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_a = '0; bus.req1_b = '0;
    rst_n          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_product", {16'd0, bus.res_product}, 32'd0);
    checkOutput("rst_id", {31'd0, bus.res_id}, 32'd0);
    applyReset();

    $display("[TB] directed table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    $display("[TB] round-robin from reset");
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 8'd5;  bus.req0_b = 8'd6;
    bus.req1_valid = 1'b1; bus.req1_a = 8'hFD; bus.req1_b = 8'd7;
    bus.res_ready  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rr_first_edge_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    nGrant = 0;
    nRes   = 0;
    waited = 0;
    while (nRes < 4 && waited < 200) begin
      @(negedge clk); #1;
      waited++;
      if ((bus.req0_ready && bus.req1_ready) == 1'b1) begin
        checkOutput("rr_two_ready", 32'd1, 32'd0);
      end
      if (bus.req0_ready && nGrant < 4) begin grants[nGrant] = 0; nGrant++; end
      if (bus.req1_ready && nGrant < 4) begin grants[nGrant] = 1; nGrant++; end
      if (bus.res_valid) begin
        checkOutput($sformatf("rr_product%0d", nRes), {16'd0, bus.res_product},
                    bus.res_id ? 32'h0000FFEB : 32'h0000001E);
        nRes++;
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    checkOutput("rr_results", 32'(nRes), 32'd4);
    checkOutput("rr_grants", 32'(nGrant), 32'd4);
    for (int g = 0; g < 4; g++) begin
      if (g < nGrant) checkOutput($sformatf("rr_order%0d", g), 32'(grants[g]), 32'(g % 2));
    end
    @(posedge clk); #1;

    $display("[TB] consumer stall in DONE");
    @(negedge clk);
    bus.res_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 8'd10; bus.req0_b = 8'hFD;
    #1;
    waited = 0;
    while (!bus.req0_ready && waited < 20) begin @(negedge clk); #1; waited++; end
    checkOutput("stall_accept", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 8'd2; bus.req1_b = 8'd3;
    waited = 0;
    while (!bus.res_valid && waited < 40) begin @(posedge clk); #1; waited++; end
    checkOutput("stall_latency", 32'(waited), 32'd8);
    checkOutput("stall_product", {16'd0, bus.res_product}, 32'h0000FFE2);
    heldP = bus.res_product;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stall_valid%0d", k), {31'd0, bus.res_valid}, 32'd1);
      checkOutput($sformatf("stall_hold%0d", k), {16'd0, bus.res_product}, {16'd0, heldP});
      checkOutput($sformatf("stall_id%0d", k), {31'd0, bus.res_id}, 32'd0);
      checkOutput($sformatf("stall_noready%0d", k), {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    end
    bus.res_ready = 1'b1;
    #1;
    checkOutput("handshake_noready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("post_handshake_ready", {31'd0, bus.req1_ready}, 32'd1);
    checkOutput("post_handshake_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    waited = 0;
    while (!bus.res_valid && waited < 40) begin @(posedge clk); #1; waited++; end
    checkOutput("pending_product", {16'd0, bus.res_product}, 32'h00000006);
    checkOutput("pending_id", {31'd0, bus.res_id}, 32'd1);
    @(posedge clk); #1;

    $display("[TB] reset during RUN");
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 8'd100; bus.req0_b = 8'd100;
    #1;
    waited = 0;
    while (!bus.req0_ready && waited < 20) begin @(negedge clk); #1; waited++; end
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", {31'd0, bus.res_valid}, 32'd0);
    checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midrst_product", {16'd0, bus.res_product}, 32'd0);
    checkOutput("midrst_id", {31'd0, bus.res_id}, 32'd0);
    checkOutput("midrst_ready", {31'd0, bus.req0_ready}, 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'hF9, 8'd9, 16'hFFC1, "after_reset");

    $display("[TB] randomised regression");
    for (int r = 0; r < 2000; r++) begin
      rid  = 1'($urandom);
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rexp = {{8{ra[7]}}, ra} * {{8{rb[7]}}, rb};
      applyStimulus(rid, ra, rb, rexp, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, misCount);
    $finish;
  end

endmodule
